muldiv_unit: RTL

- Parametrised, iterative multiply/divide unit that owns the HI/LO register pair.
- Supersedes the clock-gated, single-cycle HI/LO logic inside the ALU.
- Sits beside the ALU in the datapath. Controller issues mult/multu/div/divu via start/op, stalls on busy, and reads results through mfhi/mflo muxing from hi/lo.
- Supports direct HI/LO writes (mthi/mtlo) and abort on pipeline flush.

---
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake and HI/LO bus between the controller and the iterative multiply/divide unit.
interface muldiv_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             abort;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, abort, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, abort, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide, one bit per cycle, owning HI/LO.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input logic          clk_i,
   input logic          rst_ni,
   muldiv_unit_if.slave md_io
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StPrep, StRun, StFix} state_e;

   state_e             state_q;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q, opnd_q, hi_q, lo_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               neg_res_q, neg_rem_q, dz_q, busy_q, done_q;

   logic               is_signed, is_div;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, rem_shift;
   logic [2*WIDTH-1:0] acc_step, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, hi_res, lo_res;

   assign is_signed = ~op_q[0];
   assign is_div    = op_q[1];

   always_comb begin
      mag_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
      mag_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      // Remainder shifted left with the next dividend bit brought in from the quotient half.
      rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
      if (is_div) begin
         if (rem_shift >= {1'b0, opnd_q}) begin
            acc_step = {rem_shift[WIDTH-1:0] - opnd_q, acc_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_step = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      end
      prod_fix = neg_res_q ? -acc_q : acc_q;
      quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      if (dz_q) begin
         hi_res = a_q;
         lo_res = '1;
      end else if (is_div) begin
         hi_res = rem_fix;
         lo_res = quo_fix;
      end else begin
         hi_res = prod_fix[2*WIDTH-1:WIDTH];
         lo_res = prod_fix[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         opnd_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         done_q <= 1'b0;
         if (state_q != StIdle && md_io.abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (md_io.hi_we) hi_q <= md_io.wdata;
                  if (md_io.lo_we) lo_q <= md_io.wdata;
                  if (md_io.start) begin
                     op_q    <= md_io.op;
                     a_q     <= md_io.a;
                     b_q     <= md_io.b;
                     state_q <= StPrep;
                     busy_q  <= 1'b1;
                  end
               end
               StPrep: begin
                  neg_res_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                  neg_rem_q <= is_signed & a_q[WIDTH-1];
                  cnt_q     <= CNT_W'(WIDTH);
                  if (is_div) begin
                     acc_q  <= {{WIDTH{1'b0}}, mag_a};
                     opnd_q <= mag_b;
                  end else begin
                     acc_q  <= {{WIDTH{1'b0}}, mag_b};
                     opnd_q <= mag_a;
                  end
                  if (is_div && b_q == '0) begin
                     dz_q    <= 1'b1;
                     state_q <= StFix;
                  end else begin
                     dz_q    <= 1'b0;
                     state_q <= StRun;
                  end
               end
               StRun: begin
                  acc_q <= acc_step;
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) state_q <= StFix;
               end
               StFix: begin
                  hi_q   <= hi_res;
                  lo_q   <= lo_res;
                  done_q <= 1'b1;
                  // The completing edge can already accept the next operation.
                  if (md_io.start) begin
                     op_q    <= md_io.op;
                     a_q     <= md_io.a;
                     b_q     <= md_io.b;
                     state_q <= StPrep;
                  end else begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end
               end
               default: begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign md_io.busy = busy_q;
   assign md_io.done = done_q;
   assign md_io.hi   = hi_q;
   assign md_io.lo   = lo_q;
endmodule
